// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller reader: FSM states,
// button bit positions and default 50 MHz timing.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LOW,
    CLK_HIGH,
    DONE
  } nes_state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int DEF_LATCH_CYCLES = 600;
  localparam int DEF_HALF_CYCLES  = 300;
  localparam int DEF_POLL_CYCLES  = 833333;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_sync.sv
// Two-flop synchronizer for the controller data line. Resets to 1 so a
// released/unplugged line reads as "not pressed".
module nes_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q, ff_d;

  always_comb begin
    ff_d = {ff_q[0], d};
  end

  always_ff @(posedge clk) begin
    if (!reset) ff_q <= 2'b11;
    else        ff_q <= ff_d;
  end

  assign q = ff_q[1];

endmodule

// File: rtl/nes_controller_reader.sv
// NES controller protocol engine: periodic latch + 8 shift clocks per frame,
// captures the serial data into an active-high button byte with a valid strobe.
module nes_controller_reader
  import nes_pkg::*;
#(
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
  parameter int POLL_CYCLES  = DEF_POLL_CYCLES,
  parameter bit CHECK_PARAMS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nesData,
  output logic       nesLatch,
  output logic       nesClk,
  output logic [7:0] buttons,
  output logic       buttonsValid,
  output logic       busy
);

  localparam int PHASE_MAX = max_int(LATCH_CYCLES, HALF_CYCLES);
  localparam int PW        = $clog2(PHASE_MAX);
  localparam int CW        = $clog2(POLL_CYCLES);

  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);
  localparam logic [2:0]    FIRST_BIT  = 3'(BTN_A);
  localparam logic [2:0]    LAST_BIT   = 3'(BTN_RIGHT);

  if (CHECK_PARAMS) begin : g_param_chk
    if (LATCH_CYCLES < 1) begin : g_latch
      $error("LATCH_CYCLES must be >= 1");
    end
    if (HALF_CYCLES < 4) begin : g_half
      $error("HALF_CYCLES must be >= 4");
    end
    if (POLL_CYCLES <= LATCH_CYCLES + 16 * HALF_CYCLES) begin : g_poll
      $error("POLL_CYCLES must exceed the frame length");
    end
  end

  nes_state_t    state_q, state_d;
  logic [CW-1:0] poll_q, poll_d;
  logic          start_req_q, start_req_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    buttons_q, buttons_d;
  logic          nes_latch_q, nes_latch_d;
  logic          nes_clk_q, nes_clk_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          data_sync;
  logic          wrap;
  logic          start_pend;

  nes_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (nesData),
    .q    (data_sync)
  );

  always_comb begin
    wrap        = (poll_q == POLL_LAST);
    poll_d      = wrap ? '0 : poll_q + 1'b1;
    // A wrap that lands while a frame is running stays pending until IDLE.
    start_pend  = start_req_q | wrap;
    start_req_d = start_pend;
    state_d     = state_q;
    phase_d     = phase_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    buttons_d   = buttons_q;

    case (state_q)
      IDLE: begin
        if (start_pend) begin
          state_d     = LATCH;
          start_req_d = 1'b0;
          phase_d     = '0;
        end
      end
      LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d   = CLK_LOW;
          phase_d   = '0;
          bit_idx_d = FIRST_BIT;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      CLK_LOW: begin
        if (phase_q == HALF_LAST) begin
          shift_d[bit_idx_q] = ~data_sync;
          state_d            = CLK_HIGH;
          phase_d            = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      CLK_HIGH: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            state_d = DONE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = CLK_LOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the flops line up with it.
    if (state_d == DONE) buttons_d = shift_q;
    nes_latch_d = (state_d == LATCH);
    nes_clk_d   = (state_d == CLK_HIGH);
    valid_d     = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      poll_q      <= '0;
      start_req_q <= 1'b0;
      phase_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      buttons_q   <= '0;
      nes_latch_q <= 1'b0;
      nes_clk_q   <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      poll_q      <= poll_d;
      start_req_q <= start_req_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      nes_latch_q <= nes_latch_d;
      nes_clk_q   <= nes_clk_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign nesLatch     = nes_latch_q;
  assign nesClk       = nes_clk_q;
  assign buttons      = buttons_q;
  assign buttonsValid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader: a behavioural NES pad feeds each DUT, the
// pressed pattern is queued at latch time and checked when buttonsValid fires.
module tb_nes_controller_reader;

  localparam int L = 4, H = 4, P1 = 100, P2 = 60;
  localparam int FRAME = L + 16 * H + 1;

  logic clk = 1'b0;
  logic rst_n, rst2_n;
  logic nes_data, nes_latch, nes_clk, valid, busy;
  logic nes_data2, nes_latch2, nes_clk2, valid2, busy2;
  logic [7:0] buttons, buttons2;

  always #5 clk = ~clk;

  nes_controller_reader #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .POLL_CYCLES(P1)) dut (
    .clk(clk), .reset(rst_n), .nesData(nes_data), .nesLatch(nes_latch), .nesClk(nes_clk),
    .buttons(buttons), .buttonsValid(valid), .busy(busy));

  // Poll interval shorter than a frame: requests must be deferred, never lost.
  nes_controller_reader #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .POLL_CYCLES(P2), .CHECK_PARAMS(1'b0)) dut2 (
    .clk(clk), .reset(rst2_n), .nesData(nes_data2), .nesLatch(nes_latch2), .nesClk(nes_clk2),
    .buttons(buttons2), .buttonsValid(valid2), .busy(busy2));

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit rst_at_edge = 1'b0, rst2_at_edge = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_at_edge  = rst_n;
    rst2_at_edge = rst2_n;
  end

  // Controller model 1: latch loads the pattern, each nesClk rise shifts.
  int mode = 0;          // 0: A+Start, 1: unplugged, 2: alternate FF/00, 3: random
  bit alt = 1'b0;
  logic [7:0] pad = 8'h00;
  int sh_idx = 8;
  logic [7:0] exp_q[$];

  always @(posedge nes_latch or posedge nes_clk) begin
    if (nes_latch) begin
      case (mode)
        0:       pad = 8'h09;
        1:       pad = 8'h00;
        2:       begin pad = alt ? 8'h00 : 8'hFF; alt = ~alt; end
        default: pad = 8'($urandom);
      endcase
      exp_q.push_back(pad);
      sh_idx = 0;
    end else begin
      sh_idx++;
    end
  end
  assign nes_data = (mode == 1 || sh_idx > 7) ? 1'b1 : ~pad[sh_idx[2:0]];

  // Controller model 2: fresh random pattern every frame.
  logic [7:0] pad2 = 8'h00;
  int sh_idx2 = 8;
  logic [7:0] exp2_q[$];

  always @(posedge nes_latch2 or posedge nes_clk2) begin
    if (nes_latch2) begin
      pad2 = 8'($urandom);
      exp2_q.push_back(pad2);
      sh_idx2 = 0;
    end else begin
      sh_idx2++;
    end
  end
  assign nes_data2 = (sh_idx2 > 7) ? 1'b1 : ~pad2[sh_idx2[2:0]];

  // Monitor 1
  int frame_cyc = 0, pulses = 0, last_valid_t = -1, n_valid = 0;
  logic prev_valid = 1'b0, prev_clk = 1'b0;
  logic [7:0] prev_buttons = 8'h00;

  always @(negedge clk) begin
    logic [7:0] e;
    if (!busy) begin
      frame_cyc = 0;
      pulses    = 0;
    end else begin
      frame_cyc++;
      if (nes_clk && !prev_clk) pulses++;
    end
    chk("latch_clk_overlap", 32'(nes_latch & nes_clk), 32'h0);
    if (!rst_at_edge) begin
      chk("reset_buttons", 32'(buttons), 32'h0);
      chk("reset_valid", 32'(valid), 32'h0);
      last_valid_t = -1;
    end else if (valid) begin
      chk("valid_width", 32'(prev_valid), 32'h0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("buttons", 32'(buttons), 32'(e));
      end
      chk("frame_len", 32'(frame_cyc), 32'(FRAME));
      chk("clk_pulses", 32'(pulses), 32'd8);
      if (last_valid_t >= 0) chk("valid_period", 32'(cyc - last_valid_t), 32'(P1));
      last_valid_t = cyc;
      n_valid++;
    end else begin
      chk("buttons_hold", 32'(buttons), 32'(prev_buttons));
    end
    prev_valid   = valid;
    prev_clk     = nes_clk;
    prev_buttons = buttons;
  end

  // Monitor 2: back-to-back frames separated by a single IDLE cycle.
  int frame_cyc2 = 0, pulses2 = 0, last_valid2_t = -1, n_valid2 = 0;
  logic prev_valid2 = 1'b0, prev_clk2 = 1'b0;
  logic [7:0] prev_buttons2 = 8'h00;

  always @(negedge clk) begin
    logic [7:0] e;
    if (!busy2) begin
      frame_cyc2 = 0;
      pulses2    = 0;
    end else begin
      frame_cyc2++;
      if (nes_clk2 && !prev_clk2) pulses2++;
    end
    chk("dut2_latch_clk_overlap", 32'(nes_latch2 & nes_clk2), 32'h0);
    if (rst2_at_edge && valid2) begin
      chk("dut2_valid_width", 32'(prev_valid2), 32'h0);
      if (exp2_q.size() == 0) begin
        chk("dut2_unexpected_valid", 32'(valid2), 32'h0);
      end else begin
        e = exp2_q.pop_front();
        chk("dut2_buttons", 32'(buttons2), 32'(e));
      end
      chk("dut2_frame_len", 32'(frame_cyc2), 32'(FRAME));
      chk("dut2_clk_pulses", 32'(pulses2), 32'd8);
      if (last_valid2_t >= 0) chk("dut2_valid_period", 32'(cyc - last_valid2_t), 32'(FRAME + 1));
      last_valid2_t = cyc;
      n_valid2++;
    end else if (rst2_at_edge) begin
      chk("dut2_buttons_hold", 32'(buttons2), 32'(prev_buttons2));
    end
    prev_valid2   = valid2;
    prev_clk2     = nes_clk2;
    prev_buttons2 = buttons2;
  end

  task automatic wait_frames(input int k);
    int target = n_valid + k;
    int t = 0;
    while (n_valid < target && t < k * 3 * P1) begin
      @(negedge clk);
      t++;
    end
    chk("frame_timeout", 32'(n_valid >= target), 32'h1);
  endtask

  task automatic release_and_time_first_latch(input string nm);
    int n = 0;
    rst_n = 1'b1;
    while (n < 3 * P1) begin
      @(negedge clk);
      n++;
      if (nes_latch) break;
    end
    chk(nm, 32'(n), 32'(P1));
  endtask

  initial begin
    int pc, k;
    logic prev;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_latch", 32'(nes_latch), 32'h0);
    chk("rst_clk", 32'(nes_clk), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst2_n = 1'b1;
    release_and_time_first_latch("first_latch_delay");

    mode = 0; wait_frames(3);
    mode = 1; wait_frames(3);
    mode = 2; wait_frames(4);
    mode = 3; wait_frames(5);

    // Reset in the high half of the 4th shift clock (bit 3).
    pc = 0; k = 0; prev = 1'b0;
    while (k < 3 * P1) begin
      @(negedge clk);
      k++;
      if (nes_clk && !prev) pc++;
      prev = nes_clk;
      if (pc == 4) break;
    end
    chk("reached_bit3", 32'(pc), 32'd4);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_clk", 32'(nes_clk), 32'h0);
    chk("midrst_latch", 32'(nes_latch), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_buttons", 32'(buttons), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    repeat (4) @(negedge clk);
    release_and_time_first_latch("post_reset_latch_delay");
    wait_frames(3);

    chk("dut2_enough_frames", 32'(n_valid2 >= 10), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
